// File: rtl/rs_pkg.sv
// rs_pkg: shared constants and types for the Reed-Solomon GF(256) decoder.
//   GF_POLY    low byte of the field polynomial 0x11D (alpha = 0x02)
//   NSYM       number of error-locator coefficients held
//   T_MAX      maximum number of correctable symbol errors
//   state_e    Chien search controller states
//   ALPHA_INV  alpha^(255-j mod 255): per-coefficient step for the Chien search
//   poly_degree  index of the highest non-zero byte of a locator word
package rs_pkg;

  localparam logic [7:0]  GF_POLY = 8'h1D;
  localparam int unsigned NSYM    = 16;
  localparam int unsigned T_MAX   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  // Entry j multiplies coefficient j once per scanned position, so after p
  // steps reg_j holds C_j * alpha^(-j*p) and the XOR of all regs is
  // Lambda(alpha^-p).
  localparam logic [7:0] ALPHA_INV [NSYM] = '{
    8'h01, 8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B,
    8'h83, 8'hCF, 8'hE9, 8'hFA, 8'h7D, 8'hB0, 8'h58, 8'h2C
  };

  // Highest j with a non-zero coefficient; 0 for an all-zero word.
  function automatic logic [3:0] poly_degree(input logic [NSYM*8-1:0] poly);
    logic [3:0] deg;
    deg = '0;
    for (int unsigned j = 0; j < NSYM; j++) begin
      if (poly[j*8 +: 8] != '0) deg = 4'(j);
    end
    return deg;
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// gf256_mul: combinational GF(2^8) multiplier over the field polynomial 0x11D.
//   a_i  operand A
//   b_i  operand B (tie to a constant for a constant multiplier)
//   p_o  product A*B
module gf256_mul
  import rs_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add: sh walks through a*x^i reduced modulo the field polynomial.
  always_comb begin
    acc = '0;
    sh  = a_i;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b_i[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
    end
    p_o = acc;
  end

endmodule

// File: rtl/rs_chien_search.sv
// rs_chien_search: Chien search for the GF(256) RS decoder (t = 8).
// Evaluates the error locator Lambda(x) at alpha^-p for p = 0..N_LEN-1, one
// position per clock, pulses each root as an error position and flags
// decode failure when the root count disagrees with deg(Lambda).
//   clk        clock
//   rst        synchronous active-high reset
//   poly_in    Lambda coefficients, byte j = C_j (C_0 = constant term)
//   valid_in   poly_in valid; taken only while idle
//   busy       high from the cycle after acceptance through the done cycle
//   err_valid  one-cycle pulse per root found
//   err_pos    position of the root, meaningful with err_valid
//   err_count  number of roots found, final in the done cycle
//   fail       uncorrectable flag, valid in the done cycle
//   done       one-cycle end-of-scan pulse
module rs_chien_search
  import rs_pkg::*;
#(
  parameter int unsigned N_LEN = 255,
  parameter int unsigned NCOEF = rs_pkg::NSYM,
  parameter int unsigned T_MAX = rs_pkg::T_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCOEF*8-1:0] poly_in,
  input  logic               valid_in,
  output logic               busy,
  output logic               err_valid,
  output logic [7:0]         err_pos,
  output logic [7:0]         err_count,
  output logic               fail,
  output logic               done
);

  localparam logic [7:0] P_LAST = 8'(N_LEN - 1);

  state_e     state_q;
  logic [7:0] coef_q [NCOEF];
  logic [7:0] prod   [NCOEF];
  logic [7:0] p_q;
  logic [3:0] deg_q;
  logic       busy_q;
  logic       err_valid_q;
  logic [7:0] err_pos_q;
  logic [7:0] err_count_q;
  logic       fail_q;
  logic       done_q;

  logic [7:0] sum;
  logic       root;
  logic [7:0] cnt_next;

  for (genvar j = 0; j < NCOEF; j++) begin : g_mul
    gf256_mul u_mul (
      .a_i (coef_q[j]),
      .b_i (ALPHA_INV[j]),
      .p_o (prod[j])
    );
  end

  // coef_q[0] is multiplied by alpha^0 every step, so it keeps holding C_0
  // for the whole scan and doubles as the C_0 != 0 qualifier.
  always_comb begin
    sum = '0;
    for (int unsigned j = 0; j < NCOEF; j++) begin
      sum = sum ^ coef_q[j];
    end
    root     = (sum == '0) && (coef_q[0] != '0);
    cnt_next = err_count_q + 8'(root);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int unsigned j = 0; j < NCOEF; j++) coef_q[j] <= '0;
      p_q         <= '0;
      deg_q       <= '0;
      busy_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_pos_q   <= '0;
      err_count_q <= '0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid_in) begin
            for (int unsigned j = 0; j < NCOEF; j++) coef_q[j] <= poly_in[j*8 +: 8];
            p_q         <= '0;
            deg_q       <= poly_degree(poly_in);
            err_count_q <= '0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          for (int unsigned j = 0; j < NCOEF; j++) coef_q[j] <= prod[j];
          if (root) begin
            err_valid_q <= 1'b1;
            err_pos_q   <= p_q;
            err_count_q <= cnt_next;
          end
          p_q <= p_q + 8'd1;
          // The verdict uses cnt_next so a root at the last position counts.
          if (p_q == P_LAST) begin
            done_q  <= 1'b1;
            fail_q  <= (coef_q[0] == '0) || (32'(deg_q) > T_MAX) ||
                       (cnt_next != 8'(deg_q));
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign err_valid = err_valid_q;
  assign err_pos   = err_pos_q;
  assign err_count = err_count_q;
  assign fail      = fail_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rs_chien_search.sv
// Scoreboard bench for rs_chien_search: a full-length instance (N_LEN=255)
// and a shortened one (N_LEN=20). Expected roots come from direct evaluation
// of Lambda at alpha^-p with plain GF(256) arithmetic.
module tb_rs_chien_search;

  typedef struct { int cyc; int pos; } ev_t;
  typedef struct { int cyc; int cnt; int fl; } dn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         vin [2];
  logic [127:0] pin [2];
  logic         bsy [2];
  logic         ev  [2];
  logic         dn  [2];
  logic         fl  [2];
  logic [7:0]   ep  [2];
  logic [7:0]   ec  [2];

  always #5 clk = ~clk;

  rs_chien_search #(.N_LEN(255)) u_full (
    .clk(clk), .rst(rst), .poly_in(pin[0]), .valid_in(vin[0]), .busy(bsy[0]),
    .err_valid(ev[0]), .err_pos(ep[0]), .err_count(ec[0]), .fail(fl[0]), .done(dn[0])
  );

  rs_chien_search #(.N_LEN(20)) u_short (
    .clk(clk), .rst(rst), .poly_in(pin[1]), .valid_in(vin[1]), .busy(bsy[1]),
    .err_valid(ev[1]), .err_pos(ep[1]), .err_count(ec[1]), .fail(fl[1]), .done(dn[1])
  );

  int  nl [2] = '{255, 20};
  int  acc [2] = '{-100000, -100000};
  int  ecnt = 0;
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;
  ev_t evq [2][$];
  dn_t dnq [2][$];
  int  rts [$];

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1D) : (a << 1);
    end
    return r;
  endfunction

  function automatic bit [7:0] gpow(input int e);
    bit [7:0] r = 8'h01;
    for (int i = 0; i < e; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // Lambda = product over rts of (1 + alpha^r x).
  function automatic bit [127:0] poly_of_rts();
    bit [7:0]   c [16];
    bit [7:0]   a;
    bit [127:0] w = '0;
    for (int j = 0; j < 16; j++) c[j] = 8'h00;
    c[0] = 8'h01;
    foreach (rts[k]) begin
      a = gpow(rts[k]);
      for (int j = 15; j >= 1; j--) c[j] ^= gmul(a, c[j-1]);
    end
    for (int j = 0; j < 16; j++) w[j*8 +: 8] = c[j];
    return w;
  endfunction

  // Expected behaviour of a scan accepted so that its cycle 1 has ecnt == a.
  task automatic push_exp(input int i, input bit [127:0] poly, input int a);
    bit [7:0] x, v, c0;
    int cnt = 0;
    int deg = 0;
    int f;
    acc[i] = a;
    c0 = poly[7:0];
    for (int j = 0; j < 16; j++) if (poly[j*8 +: 8] != 0) deg = j;
    for (int p = 0; p < nl[i]; p++) begin
      x = gpow((255 - p) % 255);
      v = 8'h00;
      for (int j = 15; j >= 0; j--) v = gmul(v, x) ^ poly[j*8 +: 8];
      if (v == 0 && c0 != 0) begin
        evq[i].push_back('{cyc: a + p + 1, pos: p});
        cnt++;
      end
    end
    f = (c0 == 0 || deg > 8 || cnt != deg) ? 1 : 0;
    dnq[i].push_back('{cyc: a + nl[i], cnt: cnt, fl: f});
  endtask

  task automatic start(input int i, input bit [127:0] poly);
    @(negedge clk); #1;
    push_exp(i, poly, ecnt + 1);
    pin[i] = poly;
    vin[i] = 1'b1;
    @(negedge clk); #1;
    vin[i] = 1'b0;
    repeat (nl[i]) @(negedge clk);
  endtask

  function automatic bit [127:0] rand_poly(input int i);
    int lim = (i == 0) ? 254 : 40;
    int n;
    bit [127:0] w;
    rts.delete();
    case ($urandom_range(0, 3))
      0: begin
        n = $urandom_range(0, 8);
        for (int k = 0; k < n; k++) rts.push_back($urandom_range(0, lim));
        w = poly_of_rts();
      end
      1: begin
        n = $urandom_range(9, 15);
        for (int k = 0; k < n; k++) rts.push_back($urandom_range(0, lim));
        w = poly_of_rts();
      end
      2: w = {$urandom(), $urandom(), $urandom(), $urandom()};
      default: begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) rts.push_back($urandom_range(0, lim));
        w = poly_of_rts();
        w[7:0] = 8'h00;
      end
    endcase
    return w;
  endfunction

  always @(negedge clk) begin
    int  d;
    ev_t e;
    dn_t q;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        d = ecnt - acc[i];
        chk($sformatf("busy%0d", i), int'(bsy[i]), (d >= 0 && d <= nl[i]) ? 1 : 0);
        if (ev[i]) begin
          if (evq[i].size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_err_valid%0d: got pos %0d expected no pulse", i, ep[i]);
          end else begin
            e = evq[i].pop_front();
            chk($sformatf("err_pos%0d", i), int'(ep[i]), e.pos);
            chk($sformatf("err_cycle%0d", i), ecnt, e.cyc);
          end
        end
        while (evq[i].size() > 0 && evq[i][0].cyc < ecnt) begin
          e = evq[i].pop_front();
          total++; bad++;
          $display("FAIL missed_err_valid%0d: got no pulse expected pos %0d", i, e.pos);
        end
        if (dn[i]) begin
          if (dnq[i].size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done%0d: got done expected none", i);
          end else begin
            q = dnq[i].pop_front();
            chk($sformatf("done_cycle%0d", i), ecnt, q.cyc);
            chk($sformatf("err_count%0d", i), int'(ec[i]), q.cnt);
            chk($sformatf("fail%0d", i), int'(fl[i]), q.fl);
          end
        end
        while (dnq[i].size() > 0 && dnq[i][0].cyc < ecnt) begin
          q = dnq[i].pop_front();
          total++; bad++;
          $display("FAIL missed_done%0d: got no done expected count %0d", i, q.cnt);
        end
      end
    end
  end

  task automatic check_idle_zero(input int i, input string tag);
    chk({tag, "_busy"},      int'(bsy[i]), 0);
    chk({tag, "_err_valid"}, int'(ev[i]),  0);
    chk({tag, "_err_pos"},   int'(ep[i]),  0);
    chk({tag, "_err_count"}, int'(ec[i]),  0);
    chk({tag, "_fail"},      int'(fl[i]),  0);
    chk({tag, "_done"},      int'(dn[i]),  0);
  endtask

  initial begin
    bit [127:0] w;
    rst = 1'b1;
    vin = '{1'b0, 1'b0};
    pin = '{128'h0, 128'h0};
    repeat (3) @(negedge clk);
    check_idle_zero(0, "reset_full");
    check_idle_zero(1, "reset_short");
    #1 rst = 1'b0;
    mon_en = 1'b1;

    start(0, 128'h01);
    start(0, 128'h2001);
    start(0, 128'h747501);
    start(0, 128'h010001);
    start(0, (128'h1 << 72) | 128'h1);
    start(0, 128'h0);

    // valid_in held across the whole scan: accepted once, then again in
    // cycle N_LEN+2.
    @(negedge clk); #1;
    push_exp(0, 128'h747501, ecnt + 1);
    pin[0] = 128'h747501;
    vin[0] = 1'b1;
    repeat (nl[0] + 2) @(negedge clk);
    #1 push_exp(0, 128'h747501, ecnt + 1);
    @(negedge clk); #1 vin[0] = 1'b0;
    repeat (nl[0]) @(negedge clk);

    // Reset in cycle 40 of a scan aborts it without a done pulse.
    rts = '{5, 30, 100};
    w = poly_of_rts();
    @(negedge clk); #1;
    push_exp(0, w, ecnt + 1);
    pin[0] = w;
    vin[0] = 1'b1;
    @(negedge clk); #1 vin[0] = 1'b0;
    repeat (39) @(negedge clk);
    #1 rst = 1'b1;
    evq[0].delete();
    dnq[0].delete();
    acc[0] = -100000;
    @(negedge clk);
    check_idle_zero(0, "abort");
    #1 rst = 1'b0;
    start(0, w);

    // Shortened code: root 25 lies beyond the scanned range.
    rts = '{3, 25};
    start(1, poly_of_rts());

    for (int k = 0; k < 8; k++) start(0, rand_poly(0));
    for (int k = 0; k < 12; k++) start(1, rand_poly(1));

    repeat (4) @(negedge clk);
    chk("leftover_events0", evq[0].size() + dnq[0].size(), 0);
    chk("leftover_events1", evq[1].size() + dnq[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
